// File: rtl/fc_pkg.sv
// Shared types and helpers for the fc_argmax classification stage.
package fc_pkg;

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} argmax_state_t;

  // Returns the bit pattern of the most negative two's-complement value of the given width.
  function automatic logic [63:0] most_negative(input int unsigned width);
    most_negative = 64'd1 << (width - 32'd1);
  endfunction

endpackage

// File: rtl/fc_argmax.sv
// Streaming argmax over one frame of signed class scores, reporting the winner index,
// its score and the top-2 margin on a valid/ready output held until accepted.
module fc_argmax
  import fc_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int LAYER_WIDTH = 10,
  parameter int INDEX_WIDTH = $clog2(LAYER_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [WORD_SIZE-1:0]   data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [INDEX_WIDTH-1:0] class_o,
  output logic [WORD_SIZE-1:0]   max_o,
  output logic [WORD_SIZE:0]     margin_o
);

  localparam logic [63:0] MOST_NEG_W = most_negative(WORD_SIZE);
  localparam logic signed [WORD_SIZE-1:0] MOST_NEG = MOST_NEG_W[WORD_SIZE-1:0];
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(LAYER_WIDTH - 1);

  argmax_state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0]        count_q, count_d;
  logic signed [WORD_SIZE-1:0]   max_q, max_d;
  logic signed [WORD_SIZE-1:0]   second_q, second_d;
  logic [INDEX_WIDTH-1:0]        idx_q, idx_d;
  logic [INDEX_WIDTH-1:0]        class_q, class_d;
  logic [WORD_SIZE-1:0]          max_out_q, max_out_d;
  logic [WORD_SIZE:0]            margin_q, margin_d;
  logic signed [WORD_SIZE-1:0]   data_s;

  assign data_s   = $signed(data_i);
  assign ready_o  = (state_q == ACCUM);
  assign valid_o  = (state_q == DONE);
  assign class_o  = class_q;
  assign max_o    = max_out_q;
  assign margin_o = margin_q;

  // Top-2 tracking, beat counting and result capture.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    max_d     = max_q;
    second_d  = second_q;
    idx_d     = idx_q;
    class_d   = class_q;
    max_out_d = max_out_q;
    margin_d  = margin_q;
    case (state_q)
      ACCUM: begin
        if (valid_i) begin
          if (count_q == {INDEX_WIDTH{1'b0}}) begin
            max_d    = data_s;
            idx_d    = {INDEX_WIDTH{1'b0}};
            second_d = MOST_NEG;
          end else if (data_s > max_q) begin
            second_d = max_q;
            max_d    = data_s;
            idx_d    = count_q;
          end else if (data_s > second_q) begin
            second_d = data_s;
          end else begin
            second_d = second_q;
          end
          // Last beat: publish from the freshly updated top-2, not the registered copies.
          if (count_q == LAST_IDX) begin
            class_d   = idx_d;
            max_out_d = max_d;
            margin_d  = {max_d[WORD_SIZE-1], max_d} - {second_d[WORD_SIZE-1], second_d};
            count_d   = {INDEX_WIDTH{1'b0}};
            state_d   = DONE;
          end else begin
            count_d   = count_q + INDEX_WIDTH'(1);
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = ACCUM;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ACCUM;
      count_q   <= {INDEX_WIDTH{1'b0}};
      max_q     <= {WORD_SIZE{1'b0}};
      second_q  <= {WORD_SIZE{1'b0}};
      idx_q     <= {INDEX_WIDTH{1'b0}};
      class_q   <= {INDEX_WIDTH{1'b0}};
      max_out_q <= {WORD_SIZE{1'b0}};
      margin_q  <= {(WORD_SIZE+1){1'b0}};
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      max_q     <= max_d;
      second_q  <= second_d;
      idx_q     <= idx_d;
      class_q   <= class_d;
      max_out_q <= max_out_d;
      margin_q  <= margin_d;
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Randomized and directed checks of fc_argmax against a frame-level argmax reference.
module tb_fc_argmax;

  localparam int W  = 16;
  localparam int LW = 4;
  localparam int IW = 2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  data_i;
  logic          valid_o;
  logic          ready_i;
  logic [IW-1:0] class_o;
  logic [W-1:0]  max_o;
  logic [W:0]    margin_o;

  int passed = 0;
  int total  = 0;

  fc_argmax #(.WORD_SIZE(W), .LAYER_WIDTH(LW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .class_o(class_o),
    .max_o(max_o), .margin_o(margin_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: earliest index of the maximum; second = best of the remaining entries.
  task automatic model(input logic [W-1:0] sc [LW], output int cls, output int mx, output int mg);
    int v [LW];
    int sec;
    for (int i = 0; i < LW; i++) v[i] = int'($signed(sc[i]));
    cls = 0;
    for (int i = 1; i < LW; i++) if (v[i] > v[cls]) cls = i;
    sec = -1000000;
    for (int i = 0; i < LW; i++) if (i != cls && v[i] > sec) sec = v[i];
    mx = v[cls];
    mg = mx - sec;
  endtask

  task automatic send_beat(input logic [W-1:0] v, input int gap);
    valid_i = 1'b0;
    repeat (gap) begin
      @(posedge clk_i); #1;
    end
    check("ready_before_beat", {31'd0, ready_o}, 32'd1);
    valid_i = 1'b1;
    data_i  = v;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic run_frame(input logic [W-1:0] sc [LW], input int gap, input int hold);
    int cls, mx, mg;
    logic [31:0] mxw, mgw;
    model(sc, cls, mx, mg);
    mxw = 32'(mx);
    mgw = 32'(mg);
    for (int i = 0; i < LW; i++) begin
      send_beat(sc[i], gap);
      if (i == LW - 2) check("valid_early", {31'd0, valid_o}, 32'd0);
    end
    check("valid_after_last", {31'd0, valid_o}, 32'd1);
    check("ready_in_done", {31'd0, ready_o}, 32'd0);
    check("class", {30'd0, class_o}, 32'(cls));
    check("max", {16'd0, max_o}, {16'd0, mxw[15:0]});
    check("margin", {15'd0, margin_o}, {15'd0, mgw[16:0]});
    valid_i = 1'b1;
    data_i  = 16'h7FFF;
    ready_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_i); #1;
      check("hold_valid", {31'd0, valid_o}, 32'd1);
      check("hold_ready", {31'd0, ready_o}, 32'd0);
      check("hold_class", {30'd0, class_o}, 32'(cls));
      check("hold_max", {16'd0, max_o}, {16'd0, mxw[15:0]});
      check("hold_margin", {15'd0, margin_o}, {15'd0, mgw[16:0]});
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check("handoff_valid", {31'd0, valid_o}, 32'd0);
    check("handoff_ready", {31'd0, ready_o}, 32'd1);
    check("retain_class", {30'd0, class_o}, 32'(cls));
    check("retain_margin", {15'd0, margin_o}, {15'd0, mgw[16:0]});
  endtask

  function automatic logic [W-1:0] rand_score();
    logic [W-1:0] pick [4];
    pick[0] = 16'h8000; pick[1] = 16'h7FFF; pick[2] = 16'h0000; pick[3] = 16'hFFFF;
    case ($urandom_range(0, 2))
      0:       return pick[$urandom_range(0, 3)];
      1:       return W'($urandom_range(0, 6)) - 16'd3;
      default: return W'($urandom);
    endcase
  endfunction

  logic [W-1:0] fr [LW];

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = 16'h0000;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_class", {30'd0, class_o}, 32'd0);
    check("rst_max", {16'd0, max_o}, 32'd0);
    check("rst_margin", {15'd0, margin_o}, 32'd0);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_ready", {31'd0, ready_o}, 32'd1);

    fr = '{16'h0005, 16'hFFFE, 16'h0010, 16'h0003}; run_frame(fr, 0, 0);
    check("case1_class", {30'd0, class_o}, 32'd2);
    check("case1_margin", {15'd0, margin_o}, 32'd11);
    fr = '{16'd7, 16'd7, 16'd3, 16'd1};             run_frame(fr, 0, 0);
    fr = '{16'hFFFB, 16'hFFFF, 16'hFFFD, 16'hFFF8}; run_frame(fr, 0, 1);
    fr = '{16'h8000, 16'h7FFF, 16'h8000, 16'h8000}; run_frame(fr, 0, 3);
    check("extreme_margin", {15'd0, margin_o}, 32'h0000FFFF);
    fr = '{16'd1, 16'd2, 16'd3, 16'd4};             run_frame(fr, 0, 0);
    fr = '{16'h0005, 16'hFFFE, 16'h0010, 16'h0003}; run_frame(fr, 2, 0);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < LW; i++) fr[i] = rand_score();
      run_frame(fr, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    send_beat(16'h0005, 0);
    send_beat(16'hFFFE, 0);
    reset_i = 1'b1;
    #2;
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    check("midrst_class", {30'd0, class_o}, 32'd0);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    check("midrst_ready", {31'd0, ready_o}, 32'd1);
    fr = '{16'd9, 16'd0, 16'd0, 16'd0};             run_frame(fr, 0, 0);
    check("fresh_margin", {15'd0, margin_o}, 32'd9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
